// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial adder sequencer around a half-adder pair and carry flop (optional subtract: SERIAL_ADD_SUB_EN)
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             sub_sel;

    // Two half-adder cells plus an OR form the full-adder bit slice.
    logic ha1_s, ha1_c, ha2_s, ha2_c, carry_next;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign ha1_s      = op_a[0] ^ op_b[0];
    assign ha1_c      = op_a[0] & op_b[0];
    assign ha2_s      = ha1_s ^ carry_q;
    assign ha2_c      = ha1_s & carry_q;
    assign carry_next = ha1_c | ha2_c;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT);
    assign sum       = sum_q;
    assign carry_out = carry_q;

    // Sequencer: capture operands, shift one bit pair per cycle, hold result until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            sum_q   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1: invert B and preset the carry.
                        op_a    <= a;
                        op_b    <= b ^ {WIDTH{sub_sel}};
                        carry_q <= sub_sel;
                        cnt     <= '0;
                        sum_q   <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    op_a    <= op_a >> 1;
                    op_b    <= op_b >> 1;
                    carry_q <= carry_next;
                    sum_q   <= {ha2_s, sum_q[WIDTH-1:1]};
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - directed self-checking bench for serial_add_seq
module tb_serial_add_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vs);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("wait_in_ready", {31'd0, in_ready}, 32'd1);
        a        = va;
        b        = vb;
        sub      = vs;
        in_valid = 1'b1;
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic finish_op(input string tag, input logic [7:0] es, input logic ec, input int hold);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, cyc - acc_cyc, WIDTH);
        chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        chk({tag, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
        chk({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_sum"}, {24'd0, sum}, {24'd0, es});
            chk({tag, "_hold_carry"}, {31'd0, carry_out}, {31'd0, ec});
            chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_carry", {31'd0, carry_out}, 32'd0);
        rst = 1'b0;
        tick();

        start_op(8'h5A, 8'h33, 1'b0);
        finish_op("add_5a_33", 8'h8D, 1'b0, 0);

        start_op(8'hFF, 8'h01, 1'b0);
        finish_op("add_ff_01", 8'h00, 1'b1, 0);

        start_op(8'h00, 8'h00, 1'b0);
        finish_op("add_00_00", 8'h00, 1'b0, 0);

        out_ready = 1'b0;
        start_op(8'h80, 8'h80, 1'b0);
        finish_op("backpressure_80_80", 8'h00, 1'b1, 5);

        start_op(8'h12, 8'h34, 1'b0);
        a        = 8'hFF;
        b        = 8'hFF;
        in_valid = 1'b1;
        tick();
        chk("ignore_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        in_valid = 1'b0;
        finish_op("ignore_12_34", 8'h46, 1'b0, 0);

        start_op(8'hAA, 8'h55, 1'b0);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_sum", {24'd0, sum}, 32'd0);
        chk("abort_carry", {31'd0, carry_out}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        chk("abort_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("abort_sum_after", {24'd0, sum}, 32'd0);

        start_op(8'h01, 8'h01, 1'b0);
        finish_op("add_01_01", 8'h02, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
        start_op(8'h10, 8'h01, 1'b1);
        finish_op("sub_10_01", 8'h0F, 1'b1, 0);

        start_op(8'h01, 8'h02, 1'b1);
        finish_op("sub_01_02", 8'hFF, 1'b0, 0);

        start_op(8'h5A, 8'h33, 1'b0);
        finish_op("sub0_5a_33", 8'h8D, 1'b0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
